seq_sub_64bit: RTL and testbench
================================

Name: seq_sub_64bit

Overview:
Multi-cycle 64-bit subtractor with borrow-in. It is the inverse-direction companion to the team's 64-bit ripple-carry adder: it computes a - b - b_in one digit per clock and carries the borrow between digits in a register. A start/ready/done handshake lets a controller or datapath sequencer issue operations and collect results. Registered, digit-serial operation keeps the critical path to one DIGIT_W-bit subtract.

Parameters:
DIGIT_W, 8, bits processed per cycle; must divide 64 (legal: 1, 2, 4, 8, 16, 32, 64)
NDIG, 64/DIGIT_W, derived digit count; not overridable

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request a new operation; sampled only when ready=1
a  input  64  minuend; sampled with an accepted start
b  input  64  subtrahend; sampled with an accepted start
b_in  input  1  borrow-in; sampled with an accepted start
ready  output  1  high in IDLE; block can accept start
done  output  1  one-cycle pulse; results valid
diff  output  64  (a - b - b_in) mod 2^64
b_out  output  1  unsigned borrow-out: 1 iff a < b + b_in
overflow  output  1  signed overflow of a - b - b_in in two's complement

Behaviour:
- Reset (rst=1 at a clock edge), including mid-operation:
  - FSM goes to IDLE; ready=1, done=0, diff=0, b_out=0, overflow=0.
  - Internal operand registers, digit counter and borrow register are cleared.
  - Any in-flight operation is abandoned, and no done pulse follows.
- FSM states: IDLE, RUN, DONE.
  - IDLE: ready=1. On the edge where start=1:
    - latch a, b and b_in into internal registers; borrow register <= b_in
    - digit counter <= 0; go to RUN
    - clear diff, b_out and overflow to 0
  - RUN: ready=0. On each edge, for digit i = counter:
    - {borrow, diff[i*DIGIT_W +: DIGIT_W]} <= a_dig - b_dig - borrow, computed at DIGIT_W+1 bits
    - counter increments
    - after digit NDIG-1: latch b_out from the final borrow, compute overflow, go to DONE
  - DONE: done=1 for exactly one cycle, ready=0; next edge goes to IDLE unconditionally.
- Overflow rule: overflow = (a[63] != b[63]) && (diff[63] != a[63]), using the latched operands. b_in is folded into diff.
- Latency:
  - start sampled at edge E0; digit i written at edge E(i+1).
  - done high during the cycle following edge E(NDIG), so done appears NDIG cycles after the start edge.
  - ready returns at E(NDIG+1). Throughput is one operation per NDIG+2 cycles.
- Result hold: diff, b_out and overflow hold their final values after DONE until the next accepted start or reset.
- start while ready=0 (RUN or DONE) is ignored, not queued. Changes to a, b and b_in after acceptance have no effect.
- start held high continuously: a new operation is accepted on each return to IDLE.
- Counter width is clog2(NDIG) with a minimum of 1. DIGIT_W=64 gives a single RUN cycle.
- No combinational path from any input to any output.

Test Plan:
- rst=1 for 2 cycles, then start with a=3, b=5, b_in=0 -> ready=0 for NDIG+1 cycles; done pulses once NDIG cycles after the start edge; diff=FFFFFFFFFFFFFFFE, b_out=1, overflow=0.
- a=5, b=3, b_in=1 -> diff=1, b_out=0, overflow=0. Then a=0, b=0, b_in=1 -> diff=FFFFFFFFFFFFFFFF, b_out=1.
- a=8000000000000000, b=1, b_in=0 -> diff=7FFFFFFFFFFFFFFF, b_out=0, overflow=1. Then a=FFFFFFFFFFFFFFFF, b=FFFFFFFFFFFFFFFF, b_in=1 -> diff=FFFFFFFFFFFFFFFF, b_out=1, overflow=0.
- start pulsed again mid-RUN with different operands -> ignored; the result matches the first operands and exactly one done pulse occurs.
- rst asserted at digit 3 of an operation -> next cycle ready=1, done=0, diff=0; no later done pulse. A fresh operation then completes correctly.
- 10 random (a, b, b_in) triples, run at DIGIT_W=8 and again at DIGIT_W=1 -> diff, b_out and overflow match a reference model of the full-width subtract; done latency is 8 and 64 cycles respectively.

Source files
------------

// File: rtl/seq_sub_64bit.sv
// Digit-serial 64-bit subtractor: diff = a - b - b_in, one DIGIT_W-bit digit per clock,
// borrow carried between digits in a register, start/ready/done handshake.
module seq_sub_64bit #(
  parameter int unsigned DIGIT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        b_in,
  output logic        ready,
  output logic        done,
  output logic [63:0] diff,
  output logic        b_out,
  output logic        overflow
);

  localparam int unsigned NDIG  = 64 / DIGIT_W;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             r_state;
  logic [63:0]        r_a;
  logic [63:0]        r_b;
  logic               r_borrow;
  logic [CNT_W-1:0]   r_cnt;

  logic [DIGIT_W-1:0] w_a_dig;
  logic [DIGIT_W-1:0] w_b_dig;
  logic [DIGIT_W:0]   w_sub;
  logic               w_last;

  always_comb begin
    w_a_dig = r_a[r_cnt*DIGIT_W +: DIGIT_W];
    w_b_dig = r_b[r_cnt*DIGIT_W +: DIGIT_W];
    // A negative digit result wraps, so the extra top bit is the outgoing borrow.
    w_sub   = {1'b0, w_a_dig} - {1'b0, w_b_dig} - {{DIGIT_W{1'b0}}, r_borrow};
    w_last  = (r_cnt == CNT_W'(NDIG - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      diff     <= '0;
      b_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= b_in;
            r_cnt    <= '0;
            diff     <= '0;
            b_out    <= 1'b0;
            overflow <= 1'b0;
            ready    <= 1'b0;
            r_state  <= StRun;
          end
        end
        StRun: begin
          diff[r_cnt*DIGIT_W +: DIGIT_W] <= w_sub[DIGIT_W-1:0];
          r_borrow <= w_sub[DIGIT_W];
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            // On the last digit, the digit's top bit is diff[63].
            b_out    <= w_sub[DIGIT_W];
            overflow <= (r_a[63] != r_b[63]) && (w_sub[DIGIT_W-1] != r_a[63]);
            done     <= 1'b1;
            r_state  <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          ready   <= 1'b1;
          r_state <= StIdle;
        end
        default: begin
          done    <= 1'b0;
          ready   <= 1'b1;
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sub_64bit.sv
// Directed bench for seq_sub_64bit: one instance at DIGIT_W=8 and one at DIGIT_W=1,
// checked against hand-computed vectors and a full-width subtract model.
module tb_seq_sub_64bit;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        start_v = '0;
  logic [1:0][63:0]  a_v = '0;
  logic [1:0][63:0]  b_v = '0;
  logic [1:0]        bin_v = '0;
  logic [1:0]        ready_v;
  logic [1:0]        done_v;
  logic [1:0][63:0]  diff_v;
  logic [1:0]        bout_v;
  logic [1:0]        ov_v;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_sub_64bit #(.DIGIT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .b_in(bin_v[0]),
    .ready(ready_v[0]), .done(done_v[0]), .diff(diff_v[0]), .b_out(bout_v[0]),
    .overflow(ov_v[0])
  );

  seq_sub_64bit #(.DIGIT_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]), .b_in(bin_v[1]),
    .ready(ready_v[1]), .done(done_v[1]), .diff(diff_v[1]), .b_out(bout_v[1]),
    .overflow(ov_v[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one operation on instance d; glitch_at >= 0 pulses start with other operands mid-run.
  task automatic run_op(input int d, input logic [63:0] ta, input logic [63:0] tb,
                        input logic tbin, input int glitch_at, input string tag);
    logic [64:0] m;
    logic [63:0] ediff;
    logic        eb;
    logic        eo;
    int          n;
    int          ndig;
    int          ready_hi;
    ndig  = (d == 0) ? 8 : 64;
    m     = {1'b0, ta} - {1'b0, tb} - {64'd0, tbin};
    ediff = m[63:0];
    eb    = m[64];
    eo    = (ta[63] != tb[63]) && (ediff[63] != ta[63]);
    a_v[d]     = ta;
    b_v[d]     = tb;
    bin_v[d]   = tbin;
    start_v[d] = 1'b1;
    step();
    start_v[d] = 1'b0;
    ready_hi = (ready_v[d] !== 1'b0) ? 1 : 0;
    n = 0;
    while (done_v[d] !== 1'b1 && n < 200) begin
      if (n == glitch_at) begin
        start_v[d] = 1'b1;
        a_v[d]     = ~ta;
        b_v[d]     = ta;
        bin_v[d]   = ~tbin;
      end else begin
        start_v[d] = 1'b0;
      end
      step();
      n++;
      if (ready_v[d] !== 1'b0) ready_hi++;
    end
    start_v[d] = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'(ndig));
    chk({tag, " ready_low_while_busy"}, 64'(ready_hi), 64'd0);
    chk({tag, " diff"}, diff_v[d], ediff);
    chk({tag, " b_out"}, {63'd0, bout_v[d]}, {63'd0, eb});
    chk({tag, " overflow"}, {63'd0, ov_v[d]}, {63'd0, eo});
    step();
    chk({tag, " done_one_cycle"}, {63'd0, done_v[d]}, 64'd0);
    chk({tag, " ready_back"}, {63'd0, ready_v[d]}, 64'd1);
  endtask

  initial begin
    int dones;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rbin;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset ready", {63'd0, ready_v[0]}, 64'd1);
    chk("reset done", {63'd0, done_v[0]}, 64'd0);
    chk("reset diff", diff_v[0], 64'd0);
    chk("reset b_out", {63'd0, bout_v[0]}, 64'd0);
    chk("reset overflow", {63'd0, ov_v[0]}, 64'd0);

    // Hand-computed vectors, checked directly against the listed results.
    run_op(0, 64'd3, 64'd5, 1'b0, -1, "3-5");
    chk("3-5 diff literal", diff_v[0], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("3-5 b_out literal", {63'd0, bout_v[0]}, 64'd1);
    run_op(0, 64'd5, 64'd3, 1'b1, -1, "5-3-1");
    chk("5-3-1 diff literal", diff_v[0], 64'd1);
    run_op(0, 64'd0, 64'd0, 1'b1, -1, "0-0-1");
    chk("0-0-1 diff literal", diff_v[0], 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(0, 64'h8000_0000_0000_0000, 64'd1, 1'b0, -1, "min-1");
    chk("min-1 diff literal", diff_v[0], 64'h7FFF_FFFF_FFFF_FFFF);
    chk("min-1 overflow literal", {63'd0, ov_v[0]}, 64'd1);
    run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, -1, "ones-ones-1");
    chk("ones-ones-1 diff literal", diff_v[0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ones-ones-1 b_out literal", {63'd0, bout_v[0]}, 64'd1);

    // Start mid-run with other operands must be ignored; results hold afterwards.
    run_op(0, 64'h0123_4567_89AB_CDEF, 64'h0011_2233_4455_6677, 1'b0, 3, "glitch");
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done_v[0] === 1'b1) dones++;
    end
    chk("glitch extra done", 64'(dones), 64'd0);
    chk("glitch diff held", diff_v[0], 64'h0112_2334_4556_6778);

    // Reset on the edge that would write digit 3.
    a_v[0] = 64'hDEAD_BEEF_0000_1111;
    b_v[0] = 64'h0000_0000_1234_5678;
    bin_v[0] = 1'b1;
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst ready", {63'd0, ready_v[0]}, 64'd1);
    chk("midrst done", {63'd0, done_v[0]}, 64'd0);
    chk("midrst diff", diff_v[0], 64'd0);
    chk("midrst b_out", {63'd0, bout_v[0]}, 64'd0);
    chk("midrst overflow", {63'd0, ov_v[0]}, 64'd0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done_v[0] === 1'b1) dones++;
    end
    chk("midrst no done", 64'(dones), 64'd0);
    run_op(0, 64'd1000, 64'd1, 1'b0, -1, "after_rst");
    chk("after_rst diff literal", diff_v[0], 64'd999);

    // Pseudo-random triples on both digit widths.
    for (int k = 0; k < 10; k++) begin
      ra   = {$urandom(), $urandom()};
      rb   = {$urandom(), $urandom()};
      rbin = 1'($urandom_range(1, 0));
      run_op(0, ra, rb, rbin, -1, $sformatf("rnd%0d_w8", k));
      run_op(1, ra, rb, rbin, -1, $sformatf("rnd%0d_w1", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
